// File: rtl/rv_mem_pkg.sv
// Shared definitions for the byte-wide MADDR/MWE/MD/MRDY data-memory responder.
package rv_mem_pkg;

    localparam int unsigned DATA_W          = 8;
    localparam int unsigned MADDR_W         = 32;
    localparam int unsigned IO_BIT          = 31;
    localparam int unsigned DEF_ADDR_BITS   = 12;
    localparam int unsigned DEF_WAIT_CYCLES = 2;
    localparam int unsigned CNT_W           = 4;

    typedef enum logic [1:0] {
        S_LATCH = 2'd0,
        S_COUNT = 2'd1,
        S_READY = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

    // Access captured at the start of every handshake
    typedef struct packed {
        logic [MADDR_W-1:0] addr;
        logic               we;
    } req_t;

    function automatic logic is_io(input logic [MADDR_W-1:0] addr);
        return addr[IO_BIT];
    endfunction

endpackage

// File: rtl/byte_ram.sv
// Single-port byte RAM: one synchronous write port and an enabled, registered read port.
module byte_ram
    import rv_mem_pkg::*;
#(
    parameter int unsigned ADDR_BITS = DEF_ADDR_BITS
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_we,
    input  logic                 i_re,
    input  logic                 i_clr,
    input  logic [ADDR_BITS-1:0] i_addr,
    input  logic [DATA_W-1:0]    i_wdata,
    output logic [DATA_W-1:0]    o_rdata
);

    localparam int unsigned DEPTH = 1 << ADDR_BITS;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;

    // Array has no reset so it maps onto block RAM; contents survive RST
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    // i_clr returns zero instead of array contents (unserved address space)
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= i_clr ? DATA_W'(0) : r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/byte_mem_responder.sv
// Memory-side responder of the byte bus: free-running latch/count/ready loop with
// programmable wait states, restart on any MADDR/MWE change, MD driven only for reads.
module byte_mem_responder
    import rv_mem_pkg::*;
#(
    parameter int unsigned ADDR_BITS   = DEF_ADDR_BITS,
    parameter int unsigned WAIT_CYCLES = DEF_WAIT_CYCLES
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [MADDR_W-1:0] i_maddr,
    input  logic               i_mwe,
    inout  wire  [DATA_W-1:0]  io_md,
    output logic               o_mrdy
);

    state_t                r_state;
    state_t                w_state_nxt;
    req_t                  r_req;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_mrdy;

    logic                  w_match;
    logic                  w_cnt_zero;
    logic                  w_mrdy_nxt;
    logic                  w_ram_we;
    logic                  w_ram_re;
    logic                  w_ram_clr;
    logic                  w_md_oe;
    logic [ADDR_BITS-1:0]  w_ram_addr;
    logic [DATA_W-1:0]     w_ram_rdata;

    assign w_match    = (i_maddr == r_req.addr) && (i_mwe == r_req.we);
    assign w_cnt_zero = (r_cnt == '0);
    assign w_ram_addr = r_req.addr[ADDR_BITS-1:0];
    assign w_ram_clr  = is_io(r_req.addr);

    // State register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_LATCH;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state: a changed request while counting wins over an expiring count
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_LATCH: w_state_nxt = S_COUNT;
            S_COUNT: begin
                if (!w_match) begin
                    w_state_nxt = S_LATCH;
                end else if (w_cnt_zero) begin
                    w_state_nxt = S_READY;
                end
            end
            S_READY: w_state_nxt = r_req.we ? S_LATCH : S_HOLD;
            S_HOLD:  w_state_nxt = S_LATCH;
            default: w_state_nxt = S_LATCH;
        endcase
    end

    // Outputs: completion, RAM strobes and MD drive enable
    always_comb begin
        w_mrdy_nxt = 1'b0;
        w_ram_re   = 1'b0;
        w_ram_we   = 1'b0;
        w_md_oe    = 1'b0;
        case (r_state)
            S_COUNT: begin
                if (w_match && w_cnt_zero) begin
                    w_mrdy_nxt = 1'b1;
                    w_ram_re   = 1'b1;
                end
            end
            S_READY: begin
                w_ram_we = r_req.we && i_mwe && !is_io(r_req.addr);
                w_md_oe  = !r_req.we && !i_mwe;
            end
            S_HOLD: begin
                w_md_oe = !r_req.we && !i_mwe;
            end
            default: ;
        endcase
    end

    // Request capture, wait-state counter and MRDY pulse
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_req  <= '0;
            r_cnt  <= '0;
            r_mrdy <= 1'b0;
        end else begin
            r_mrdy <= w_mrdy_nxt;
            if (r_state == S_LATCH) begin
                r_req.addr <= i_maddr;
                r_req.we   <= i_mwe;
                r_cnt      <= CNT_W'(WAIT_CYCLES);
            end else if ((r_state == S_COUNT) && w_match && !w_cnt_zero) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
        end
    end

    byte_ram #(
        .ADDR_BITS (ADDR_BITS)
    ) u_ram (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_we    (w_ram_we),
        .i_re    (w_ram_re),
        .i_clr   (w_ram_clr),
        .i_addr  (w_ram_addr),
        .i_wdata (io_md),
        .o_rdata (w_ram_rdata)
    );

    // Never drives while the initiator has MWE high, so no bus contention
    assign io_md  = w_md_oe ? w_ram_rdata : {DATA_W{1'bz}};
    assign o_mrdy = r_mrdy;

endmodule

// File: tb/tb_byte_mem_responder.sv
// Scoreboarded bench for byte_mem_responder: two instances (2 and 0 wait states) run concurrently.
`timescale 1ns/1ps
module tb_byte_mem_responder;

    localparam int unsigned W0 = 2;
    localparam int unsigned W1 = 0;

    typedef struct {
        int unsigned cyc;
        bit          rd;
        logic [7:0]  data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst    [2];
    logic [31:0] maddr  [2];
    logic        mwe    [2];
    logic [7:0]  tbmd   [2];
    logic        oe     [2];
    bit          strict [2];
    bit          pend   [2];
    logic [7:0]  pdat   [2];
    wire  [7:0]  md0;
    wire  [7:0]  md1;
    logic        mrdy0;
    logic        mrdy1;

    int unsigned cyc    = 0;
    int unsigned n_chk  = 0;
    int unsigned n_fail = 0;

    exp_t       q0 [$];
    exp_t       q1 [$];
    logic [7:0] mem0 [int];
    logic [7:0] mem1 [int];

    assign md0 = oe[0] ? tbmd[0] : 8'hzz;
    assign md1 = oe[1] ? tbmd[1] : 8'hzz;

    byte_mem_responder #(.ADDR_BITS(12), .WAIT_CYCLES(W0)) u_dut0 (
        .i_clk(clk), .i_rst(rst[0]), .i_maddr(maddr[0]), .i_mwe(mwe[0]),
        .io_md(md0), .o_mrdy(mrdy0)
    );

    byte_mem_responder #(.ADDR_BITS(12), .WAIT_CYCLES(W1)) u_dut1 (
        .i_clk(clk), .i_rst(rst[1]), .i_maddr(maddr[1]), .i_mwe(mwe[1]),
        .io_md(md1), .o_mrdy(mrdy1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic int unsigned wt(input int d);
        return (d == 0) ? W0 : W1;
    endfunction

    // Reference memory: 4 KiB aliased on MADDR[11:0]; bit 31 is unserved I/O space
    function automatic bit known(input int d, input logic [31:0] a);
        if (a[31]) return 1'b1;
        return (d == 0) ? mem0.exists(int'(a[11:0])) : mem1.exists(int'(a[11:0]));
    endfunction

    function automatic logic [7:0] ref_rd(input int d, input logic [31:0] a);
        if (a[31]) return 8'h00;
        return (d == 0) ? mem0[int'(a[11:0])] : mem1[int'(a[11:0])];
    endfunction

    function automatic void ref_wr(input int d, input logic [31:0] a, input logic [7:0] v);
        if (a[31]) return;
        if (d == 0) mem0[int'(a[11:0])] = v;
        else        mem1[int'(a[11:0])] = v;
    endfunction

    // One byte handshake starting with the responder in S_LATCH; extra = restart cycle
    task automatic access(input int d, input logic [31:0] a, input bit we,
                          input logic [7:0] wd, input int unsigned extra);
        exp_t        e;
        int unsigned w;
        w = wt(d);
        maddr[d] = a; mwe[d] = we; tbmd[d] = wd; oe[d] = we;
        e.cyc  = cyc + extra + w + 2;
        e.rd   = !we;
        e.data = we ? 8'h00 : ref_rd(d, a);
        if (d == 0) q0.push_back(e);
        else        q1.push_back(e);
        repeat (extra + w + 2) @(posedge clk);
        #1;
        if (we) ref_wr(d, a, wd);
        @(posedge clk); #1;
        if (!we) begin
            @(posedge clk); #1;
        end
    endtask

    // Start an access that is abandoned k cycles in, then complete a different one
    task automatic restart(input int d, input logic [31:0] a1, input bit we1, input logic [7:0] wd1,
                           input int unsigned k, input logic [31:0] a2, input bit we2,
                           input logic [7:0] wd2);
        maddr[d] = a1; mwe[d] = we1; tbmd[d] = wd1; oe[d] = we1;
        repeat (k) @(posedge clk);
        #1;
        access(d, a2, we2, wd2, 1);
    endtask

    task automatic rand_op(input int d);
        logic [31:0] a;
        logic [31:0] a1;
        bit          we;
        logic [7:0]  wd;
        a       = $urandom;
        a[31]   = ($urandom_range(0, 7) == 0);
        a[11:0] = 12'h100 + 12'($urandom_range(0, 15));
        we      = 1'($urandom_range(0, 1));
        if (!we && !known(d, a)) we = 1'b1;
        wd      = 8'($urandom);
        if ($urandom_range(0, 3) == 0) begin
            a1 = a ^ 32'h4;
            restart(d, a1, 1'($urandom_range(0, 1)), 8'($urandom),
                    $urandom_range(1, wt(d) + 1), a, we, wd);
        end else begin
            access(d, a, we, wd, 0);
        end
    endtask

    task automatic seq0();
        logic [31:0] word;
        word = 32'hDEADBEEF;
        for (int i = 0; i < 4; i++) access(0, 32'h10 + 32'(i), 1'b1, word[8*i +: 8], 0);
        for (int i = 0; i < 4; i++) access(0, 32'h10 + 32'(i), 1'b0, 8'h00, 0);
        // Address change coinciding with and preceding count expiry
        restart(0, 32'h20, 1'b1, 8'h99, W0 + 1, 32'h21, 1'b1, 8'h5A);
        restart(0, 32'h20, 1'b0, 8'h00, W0, 32'h21, 1'b0, 8'h00);
        // Reset while MRDY is high
        strict[0] = 1'b0;
        maddr[0] = 32'h10; mwe[0] = 1'b0; oe[0] = 1'b0;
        repeat (W0 + 2) @(posedge clk);
        #1;
        chk("mrdy_before_reset", mrdy0, 1'b1);
        rst[0] = 1'b1;
        #1;
        chk("mrdy_async_drop", mrdy0, 1'b0);
        @(posedge clk); #1;
        rst[0] = 1'b0; strict[0] = 1'b1;
        // Reset in the middle of a write: old byte must survive
        access(0, 32'h30, 1'b1, 8'h11, 0);
        maddr[0] = 32'h30; mwe[0] = 1'b1; tbmd[0] = 8'h55; oe[0] = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst[0] = 1'b1;
        #1;
        chk("mrdy_reset_mid_write", mrdy0, 1'b0);
        mwe[0] = 1'b0; oe[0] = 1'b0;
        @(posedge clk); #1;
        rst[0] = 1'b0;
        access(0, 32'h30, 1'b0, 8'h00, 0);
        // I/O space is acknowledged but never touches RAM; reads give zero
        access(0, 32'h40, 1'b1, 8'h77, 0);
        access(0, 32'h8000_0040, 1'b1, 8'hAA, 0);
        access(0, 32'h40, 1'b0, 8'h00, 0);
        access(0, 32'h8000_0040, 1'b0, 8'h00, 0);
        access(0, 32'h0001_0040, 1'b0, 8'h00, 0);
        for (int i = 0; i < 150; i++) rand_op(0);
        strict[0] = 1'b0;
    endtask

    task automatic seq1();
        for (int i = 0; i < 4; i++) access(1, 32'(i), 1'b1, 8'($urandom), 0);
        for (int i = 0; i < 4; i++) access(1, 32'(i), 1'b0, 8'h00, 0);
        for (int i = 0; i < 150; i++) rand_op(1);
        strict[1] = 1'b0;
    endtask

    task automatic mon(input int d, input logic r, input logic [7:0] m);
        exp_t e;
        bit   have;
        have = 1'b0;
        if (d == 0) begin
            if (q0.size() != 0 && q0[0].cyc == cyc) begin e = q0.pop_front(); have = 1'b1; end
        end else begin
            if (q1.size() != 0 && q1[0].cyc == cyc) begin e = q1.pop_front(); have = 1'b1; end
        end
        if (oe[d]) chk($sformatf("md_initiator_drive%0d", d), m, tbmd[d]);
        if (have) begin
            chk($sformatf("mrdy_on_time%0d", d), r, 1'b1);
            if (e.rd) begin
                chk($sformatf("md_read%0d", d), m, e.data);
                pend[d] = 1'b1;
                pdat[d] = e.data;
            end
        end else begin
            if (pend[d]) begin
                chk($sformatf("md_hold%0d", d), m, pdat[d]);
                pend[d] = 1'b0;
            end
            if (strict[d]) chk($sformatf("mrdy_spurious%0d", d), r, 1'b0);
        end
    endtask

    always @(negedge clk) begin
        mon(0, mrdy0, md0);
        mon(1, mrdy1, md1);
    end

    initial begin
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1; maddr[d] = '0; mwe[d] = 1'b0; tbmd[d] = '0; oe[d] = 1'b0;
            strict[d] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("reset_mrdy0", mrdy0, 1'b0);
        chk("reset_mrdy1", mrdy1, 1'b0);
        rst[0] = 1'b0; rst[1] = 1'b0;
        strict[0] = 1'b1; strict[1] = 1'b1;
        fork
            seq0();
            seq1();
        join
        repeat (5) @(posedge clk);
        #1;
        chk("queue0_drained", q0.size(), 0);
        chk("queue1_drained", q1.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
